// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with exact fill level, programmable almost-full/almost-empty,
// sticky overflow/underflow flags and an optional first-word-fall-through read port.
module sync_fifo_level #(
    parameter int BITS      = 32,
    parameter int SIZE      = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = SIZE - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      p_write_en,
    input  logic [BITS-1:0]           p_write_data,
    output logic                      p_write_full,
    output logic                      p_write_almost_full,
    input  logic                      p_read_en,
    output logic [BITS-1:0]           p_read_data,
    output logic                      p_read_empty,
    output logic                      p_read_almost_empty,
    output logic [$clog2(SIZE+1)-1:0] p_level,
    output logic                      p_overflow,
    output logic                      p_underflow,
    input  logic                      p_clear_err
);
    localparam int LW = $clog2(SIZE + 1);
    localparam int PW = $clog2(SIZE);
    localparam logic [LW-1:0] FULL_LVL = LW'(SIZE);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_LVL   = LW'(AE_THRESH);
    localparam logic [PW-1:0] LAST_PTR = PW'(SIZE - 1);

    generate
        if (SIZE < 2) begin : g_bad_size
            $fatal(1, "sync_fifo_level: SIZE must be at least 2");
        end
        if (AF_THRESH < 1 || AF_THRESH > SIZE) begin : g_bad_af
            $fatal(1, "sync_fifo_level: AF_THRESH must lie in 1..SIZE");
        end
        if (AE_THRESH < 0 || AE_THRESH > SIZE - 1) begin : g_bad_ae
            $fatal(1, "sync_fifo_level: AE_THRESH must lie in 0..SIZE-1");
        end
    endgenerate

    logic [BITS-1:0] mem [SIZE];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            wr_acc;
    logic            rd_acc;
    logic [LW-1:0]   level_nxt;

    // Acceptance uses the registered flags, so a full FIFO still takes a read
    // (and an empty one a write) in the same cycle as the rejected request.
    assign wr_acc = p_write_en && !p_write_full;
    assign rd_acc = p_read_en && !p_read_empty;

    always_comb begin
        level_nxt = p_level;
        if (wr_acc && !rd_acc) begin
            level_nxt = p_level + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            level_nxt = p_level - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            p_level             <= '0;
            p_write_full        <= 1'b0;
            p_read_empty        <= 1'b1;
            p_write_almost_full <= 1'b0;
            p_read_almost_empty <= 1'b1;
            p_overflow          <= 1'b0;
            p_underflow         <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            p_level             <= level_nxt;
            p_write_full        <= (level_nxt == FULL_LVL);
            p_read_empty        <= (level_nxt == '0);
            p_write_almost_full <= (level_nxt >= AF_LVL);
            p_read_almost_empty <= (level_nxt <= AE_LVL);
            // A new error event outranks a clear in the same cycle.
            if (p_write_en && p_write_full) begin
                p_overflow <= 1'b1;
            end else if (p_clear_err) begin
                p_overflow <= 1'b0;
            end
            if (p_read_en && p_read_empty) begin
                p_underflow <= 1'b1;
            end else if (p_clear_err) begin
                p_underflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= p_write_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign p_read_data = p_read_empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_read_data <= '0;
                end else if (rd_acc) begin
                    p_read_data <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_level.sv
// Directed bench for sync_fifo_level: a 16-deep standard instance, a 5-deep
// instance for non-power-of-two wrap, and a 4-deep first-word-fall-through instance.
module tb_sync_fifo_level;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_we, a_re, a_clr, a_full, a_af, a_empty, a_ae, a_ovf, a_unf;
    logic [31:0] a_wd, a_rd;
    logic [4:0]  a_lvl;
    logic        b_we, b_re, b_clr, b_full, b_af, b_empty, b_ae, b_ovf, b_unf;
    logic [31:0] b_wd, b_rd;
    logic [2:0]  b_lvl;
    logic        c_we, c_re, c_clr, c_full, c_af, c_empty, c_ae, c_ovf, c_unf;
    logic [31:0] c_wd, c_rd;
    logic [2:0]  c_lvl;

    int n_assert = 0;
    int n_fail   = 0;

    sync_fifo_level #(.BITS(32), .SIZE(16), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) u_a (
        .clk(clk), .rst(rst), .p_write_en(a_we), .p_write_data(a_wd), .p_write_full(a_full),
        .p_write_almost_full(a_af), .p_read_en(a_re), .p_read_data(a_rd), .p_read_empty(a_empty),
        .p_read_almost_empty(a_ae), .p_level(a_lvl), .p_overflow(a_ovf), .p_underflow(a_unf),
        .p_clear_err(a_clr));

    sync_fifo_level #(.BITS(32), .SIZE(5), .FWFT(0)) u_b (
        .clk(clk), .rst(rst), .p_write_en(b_we), .p_write_data(b_wd), .p_write_full(b_full),
        .p_write_almost_full(b_af), .p_read_en(b_re), .p_read_data(b_rd), .p_read_empty(b_empty),
        .p_read_almost_empty(b_ae), .p_level(b_lvl), .p_overflow(b_ovf), .p_underflow(b_unf),
        .p_clear_err(b_clr));

    sync_fifo_level #(.BITS(32), .SIZE(4), .FWFT(1)) u_c (
        .clk(clk), .rst(rst), .p_write_en(c_we), .p_write_data(c_wd), .p_write_full(c_full),
        .p_write_almost_full(c_af), .p_read_en(c_re), .p_read_data(c_rd), .p_read_empty(c_empty),
        .p_read_almost_empty(c_ae), .p_level(c_lvl), .p_overflow(c_ovf), .p_underflow(c_unf),
        .p_clear_err(c_clr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a_we = 0; a_re = 0; a_clr = 0; a_wd = '0;
        b_we = 0; b_re = 0; b_clr = 0; b_wd = '0;
        c_we = 0; c_re = 0; c_clr = 0; c_wd = '0;
        #2;
        chk("rst_level", 32'(a_lvl), 0);
        chk("rst_empty", 32'(a_empty), 1);
        chk("rst_full", 32'(a_full), 0);
        chk("rst_ae", 32'(a_ae), 1);
        chk("rst_af", 32'(a_af), 0);
        chk("rst_rdata", a_rd, 0);
        chk("rst_ovf", 32'(a_ovf), 0);
        chk("rst_unf", 32'(a_unf), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Reset mid-stream
        for (int i = 0; i < 5; i++) begin
            a_we = 1; a_wd = 32'h100 + 32'(i);
            tick();
        end
        a_we = 0;
        chk("t1_level5", 32'(a_lvl), 5);
        chk("t1_ae_low", 32'(a_ae), 0);
        a_re = 1;
        tick();
        a_re = 0;
        chk("t1_rd_first", a_rd, 32'h100);
        chk("t1_level4", 32'(a_lvl), 4);
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_level", 32'(a_lvl), 0);
        chk("t1_rst_empty", 32'(a_empty), 1);
        chk("t1_rst_full", 32'(a_full), 0);
        chk("t1_rst_ae", 32'(a_ae), 1);
        chk("t1_rst_af", 32'(a_af), 0);
        chk("t1_rst_rdata", a_rd, 0);
        #1 rst = 1'b0;
        a_re = 1;
        tick();
        a_re = 0;
        chk("t1_unf_after_rst", 32'(a_unf), 1);
        chk("t1_rd_after_rst", a_rd, 0);
        a_clr = 1;
        tick();
        a_clr = 0;
        chk("t1_unf_clr", 32'(a_unf), 0);

        // Fill and drain
        for (int i = 0; i < 16; i++) begin
            a_we = 1; a_wd = 32'(i);
            tick();
            if (i == 12) chk("t2_af_13", 32'(a_af), 0);
            if (i == 13) chk("t2_af_14", 32'(a_af), 1);
            if (i == 14) chk("t2_full_15", 32'(a_full), 0);
        end
        chk("t2_full_16", 32'(a_full), 1);
        chk("t2_level16", 32'(a_lvl), 16);
        a_wd = 32'hDEAD;
        tick();
        a_we = 0;
        chk("t2_ovf", 32'(a_ovf), 1);
        chk("t2_level_ovf", 32'(a_lvl), 16);
        a_clr = 1;
        tick();
        a_clr = 0;
        chk("t2_ovf_clr", 32'(a_ovf), 0);
        for (int i = 0; i < 16; i++) begin
            a_re = 1;
            tick();
            chk("t2_drain_data", a_rd, 32'(i));
            if (i == 12) chk("t2_ae_3", 32'(a_ae), 0);
            if (i == 13) chk("t2_ae_2", 32'(a_ae), 1);
        end
        a_re = 0;
        chk("t2_empty", 32'(a_empty), 1);
        chk("t2_level0", 32'(a_lvl), 0);

        // Error flags
        a_re = 1;
        tick();
        a_re = 0;
        chk("t4_unf", 32'(a_unf), 1);
        chk("t4_rd_hold", a_rd, 32'd15);
        a_clr = 1;
        tick();
        chk("t4_clr_alone", 32'(a_unf), 0);
        a_re = 1;
        tick();
        a_clr = 0; a_re = 0;
        chk("t4_set_wins", 32'(a_unf), 1);
        a_clr = 1;
        tick();
        a_clr = 0;
        chk("t4_clr_again", 32'(a_unf), 0);
        a_we = 1; a_re = 1; a_wd = 32'h55;
        tick();
        a_we = 0; a_re = 0;
        chk("t4_empty_rw_level", 32'(a_lvl), 1);
        chk("t4_empty_rw_unf", 32'(a_unf), 1);
        chk("t4_empty_rw_rd", a_rd, 32'd15);
        a_clr = 1;
        tick();
        a_clr = 0;

        // Concurrent traffic at level 8
        for (int i = 0; i < 7; i++) begin
            a_we = 1; a_wd = 32'h200 + 32'(i);
            tick();
        end
        chk("t3_level8", 32'(a_lvl), 8);
        for (int j = 0; j < 20; j++) begin
            a_we = 1; a_re = 1; a_wd = 32'h300 + 32'(j);
            tick();
            if (j == 0)     chk("t3_data", a_rd, 32'h55);
            else if (j < 8) chk("t3_data", a_rd, 32'h200 + 32'(j - 1));
            else            chk("t3_data", a_rd, 32'h300 + 32'(j - 8));
            chk("t3_level", 32'(a_lvl), 8);
        end
        a_we = 0; a_re = 0;
        chk("t3_ovf", 32'(a_ovf), 0);
        chk("t3_unf", 32'(a_unf), 0);

        // Non-power-of-two wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) begin
                b_we = 1; b_wd = 32'h1000 + 32'(r * 16 + i);
                tick();
                if (i == 3) chk("t5_not_full", 32'(b_full), 0);
            end
            b_we = 0;
            chk("t5_full", 32'(b_full), 1);
            chk("t5_level5", 32'(b_lvl), 5);
            for (int i = 0; i < 5; i++) begin
                b_re = 1;
                tick();
                chk("t5_data", b_rd, 32'h1000 + 32'(r * 16 + i));
            end
            b_re = 0;
            chk("t5_level0", 32'(b_lvl), 0);
            chk("t5_empty", 32'(b_empty), 1);
        end
        for (int i = 0; i < 5; i++) begin
            b_we = 1; b_wd = 32'h2000 + 32'(i);
            tick();
        end
        b_re = 1; b_wd = 32'hEE;
        tick();
        b_we = 0; b_re = 0;
        chk("t5_full_rw_rd", b_rd, 32'h2000);
        chk("t5_full_rw_level", 32'(b_lvl), 4);
        chk("t5_full_rw_ovf", 32'(b_ovf), 1);
        chk("t5_full_rw_full", 32'(b_full), 0);

        // First-word-fall-through
        chk("t6_init_empty", 32'(c_empty), 1);
        chk("t6_init_rd", c_rd, 0);
        c_we = 1; c_wd = 32'hA5;
        tick();
        c_we = 0;
        chk("t6_empty_low", 32'(c_empty), 0);
        chk("t6_head", c_rd, 32'hA5);
        chk("t6_level1", 32'(c_lvl), 1);
        c_re = 1;
        tick();
        c_re = 0;
        chk("t6_pop_empty", 32'(c_empty), 1);
        chk("t6_pop_rd", c_rd, 0);
        c_we = 1; c_wd = 32'h11;
        tick();
        c_wd = 32'h22;
        tick();
        c_we = 0;
        chk("t6_head2", c_rd, 32'h11);
        c_re = 1;
        tick();
        c_re = 0;
        chk("t6_next", c_rd, 32'h22);
        chk("t6_not_empty", 32'(c_empty), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
